combat_ctrl: RTL

Frame-synchronous combat state controller for the two-player fighting display. It sits directly downstream of the pixel-level hit detection and consumes the per-pixel `p1_hit`/`p2_hit` overlap strobes. It converts them into one damage event per player per frame, tracks health, invulnerability, KO and round count, and drives the health-bar widths, hit-flash and movement-freeze signals back into the renderer and movement logic. It also provides the match reset driven by a switch.

---
 rtl/combat_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/combat_ctrl.sv
// Frame-synchronous combat state controller: per-frame hit latching, health, KO pause,
// round counting and match reset. Define COMBAT_IFRAMES_EN to enable invulnerability frames.
module combat_ctrl #(
  parameter int unsigned MAX_HEALTH    = 300,
  parameter int unsigned DAMAGE        = 100,
  parameter int unsigned IFRAMES       = 30,
  parameter int unsigned KO_FRAMES     = 120,
  parameter int unsigned ROUNDS_TO_WIN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       v_sync,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       restart,
  output logic [9:0] p1_health,
  output logic [9:0] p2_health,
  output logic       p1_flash,
  output logic       p2_flash,
  output logic       freeze,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] winner,
  output logic       match_over
);

  typedef enum logic [1:0] {StFight, StKo, StOver} state_e;

  localparam logic [9:0] MaxHp  = 10'(MAX_HEALTH);
  localparam logic [7:0] KoLast = 8'(KO_FRAMES - 1);
  localparam logic [1:0] RndWin = 2'(ROUNDS_TO_WIN);

  state_e     state_q;
  logic       vs_q, restart_q, hl1_q, hl2_q;
  logic [9:0] hp1_q, hp2_q;
  logic [1:0] rnd1_q, rnd2_q, winner_q;
  logic       freeze_q, over_q, flash1_q, flash2_q;
  logic [7:0] ko_cnt_q;

  logic       tick, restart_edge, acc1, acc2, ko1, ko2;
  logic [9:0] hp1_nx, hp2_nx;

  function automatic logic [9:0] hit_hp(input logic [9:0] h);
    if (32'(h) <= DAMAGE) return '0;
    return 10'(32'(h) - DAMAGE);
  endfunction

`ifdef COMBAT_IFRAMES_EN
  localparam logic [7:0] IfLoad = 8'(IFRAMES);
  logic [7:0] if1_q, if2_q;
  assign acc1 = hl1_q && (if1_q == 8'd0);
  assign acc2 = hl2_q && (if2_q == 8'd0);
`else
  assign acc1 = hl1_q;
  assign acc2 = hl2_q;
`endif

  always_comb begin
    tick         = vs_q & ~v_sync;
    restart_edge = restart & ~restart_q;
    hp1_nx       = acc1 ? hit_hp(hp1_q) : hp1_q;
    hp2_nx       = acc2 ? hit_hp(hp2_q) : hp2_q;
    ko1          = (hp1_nx == 10'd0);
    ko2          = (hp2_nx == 10'd0);
  end

  always_ff @(posedge clk) begin
    // Tracks the switch level even through reset so releasing rst never fakes an edge.
    restart_q <= restart;
    if (rst || restart_edge) begin
      state_q  <= StFight;
      vs_q     <= 1'b1;
      hl1_q    <= 1'b0;
      hl2_q    <= 1'b0;
      hp1_q    <= MaxHp;
      hp2_q    <= MaxHp;
      rnd1_q   <= 2'd0;
      rnd2_q   <= 2'd0;
      winner_q <= 2'd0;
      freeze_q <= 1'b0;
      over_q   <= 1'b0;
      flash1_q <= 1'b0;
      flash2_q <= 1'b0;
      ko_cnt_q <= 8'd0;
`ifdef COMBAT_IFRAMES_EN
      if1_q    <= 8'd0;
      if2_q    <= 8'd0;
`endif
    end else begin
      vs_q  <= v_sync;
      // A strobe on the tick cycle belongs to the new frame.
      hl1_q <= (hl1_q & ~tick) | p1_hit;
      hl2_q <= (hl2_q & ~tick) | p2_hit;
      if (tick) begin
        unique case (state_q)
          StFight: begin
            hp1_q <= hp1_nx;
            hp2_q <= hp2_nx;
`ifdef COMBAT_IFRAMES_EN
            if1_q    <= acc1 ? IfLoad : ((if1_q != 8'd0) ? if1_q - 8'd1 : 8'd0);
            if2_q    <= acc2 ? IfLoad : ((if2_q != 8'd0) ? if2_q - 8'd1 : 8'd0);
            flash1_q <= acc1 || (if1_q > 8'd1);
            flash2_q <= acc2 || (if2_q > 8'd1);
`else
            flash1_q <= acc1;
            flash2_q <= acc2;
`endif
            if (ko1 || ko2) begin
              state_q  <= StKo;
              freeze_q <= 1'b1;
              ko_cnt_q <= 8'd0;
              if (ko1 && ko2) begin
                winner_q <= 2'b11;
              end else if (ko2) begin
                winner_q <= 2'b01;
                rnd1_q   <= rnd1_q + 2'd1;
              end else begin
                winner_q <= 2'b10;
                rnd2_q   <= rnd2_q + 2'd1;
              end
            end
          end
          StKo: begin
`ifndef COMBAT_IFRAMES_EN
            flash1_q <= 1'b0;
            flash2_q <= 1'b0;
`endif
            if (ko_cnt_q == KoLast) begin
              if (rnd1_q == RndWin || rnd2_q == RndWin) begin
                state_q <= StOver;
                over_q  <= 1'b1;
              end else begin
                state_q  <= StFight;
                freeze_q <= 1'b0;
                winner_q <= 2'd0;
                hp1_q    <= MaxHp;
                hp2_q    <= MaxHp;
                flash1_q <= 1'b0;
                flash2_q <= 1'b0;
`ifdef COMBAT_IFRAMES_EN
                if1_q    <= 8'd0;
                if2_q    <= 8'd0;
`endif
              end
            end else begin
              ko_cnt_q <= ko_cnt_q + 8'd1;
            end
          end
          StOver: ;
          default: state_q <= StFight;
        endcase
      end
    end
  end

  assign p1_health  = hp1_q;
  assign p2_health  = hp2_q;
  assign p1_flash   = flash1_q;
  assign p2_flash   = flash2_q;
  assign freeze     = freeze_q;
  assign p1_rounds  = rnd1_q;
  assign p2_rounds  = rnd2_q;
  assign winner     = winner_q;
  assign match_over = over_q;

endmodule
